// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the core control FSM and the M-extension unit.
// The core side drives operands and start; the unit returns busy/done/result.
interface mul_div_unit_if;
    logic        i_Start;
    logic [2:0]  i_Funct3;
    logic [31:0] i_Operand_A;
    logic [31:0] i_Operand_B;
    logic        o_Busy;
    logic        o_Done;
    logic [31:0] o_Result;

    modport master (
        output i_Start, i_Funct3, i_Operand_A, i_Operand_B,
        input  o_Busy, o_Done, o_Result
    );

    modport slave (
        input  i_Start, i_Funct3, i_Operand_A, i_Operand_B,
        output o_Busy, o_Done, o_Result
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: one shared 32-step shift/add/subtract datapath,
// fixed 33-cycle latency from accepting edge to the o_Done pulse for every op.
module mul_div_unit (
    input  logic           i_Clk,
    input  logic           i_Reset,
    mul_div_unit_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    logic [1:0]  state_reg;
    logic [4:0]  step_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] a_orig_reg;
    logic [31:0] opnd_reg;
    logic [63:0] prod_reg;
    logic        a_neg_reg;
    logic        b_neg_reg;
    logic        b_zero_reg;
    logic        done_reg;
    logic [31:0] result_reg;

    logic        a_signed_in;
    logic        b_signed_in;
    logic        a_neg_in;
    logic        b_neg_in;
    logic [31:0] a_mag_in;
    logic [31:0] b_mag_in;

    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic [32:0] rem_shift;
    logic [33:0] rem_trial;
    logic [63:0] div_step;
    logic [63:0] step_next;

    logic        sign_diff;
    logic [63:0] prod_signed;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] result_next;
    logic        unused_bits;

    // Operand signedness; MUL low word is sign-agnostic so it runs unsigned.
    always_comb begin
        a_signed_in = 1'b0;
        b_signed_in = 1'b0;
        case (bus.i_Funct3)
            3'b001, 3'b100, 3'b110: begin
                a_signed_in = 1'b1;
                b_signed_in = 1'b1;
            end
            3'b010:  a_signed_in = 1'b1;
            default: ;
        endcase
    end

    assign a_neg_in = a_signed_in & bus.i_Operand_A[31];
    assign b_neg_in = b_signed_in & bus.i_Operand_B[31];
    assign a_mag_in = a_neg_in ? (~bus.i_Operand_A + 32'd1) : bus.i_Operand_A;
    assign b_mag_in = b_neg_in ? (~bus.i_Operand_B + 32'd1) : bus.i_Operand_B;

    // One iteration of either algorithm. Both start from {0, |A|} with |B| in opnd_reg:
    // multiply consumes the low half as the multiplier, divide shifts it out as the dividend.
    always_comb begin
        mul_sum   = {1'b0, prod_reg[63:32]} + {1'b0, opnd_reg};
        mul_step  = prod_reg[0] ? {mul_sum, prod_reg[31:1]} : {1'b0, prod_reg[63:1]};
        rem_shift = {prod_reg[63:32], prod_reg[31]};
        rem_trial = {1'b0, rem_shift} - {2'b0, opnd_reg};
        div_step  = rem_trial[33] ? {rem_shift[31:0], prod_reg[30:0], 1'b0}
                                  : {rem_trial[31:0], prod_reg[30:0], 1'b1};
        step_next = funct3_reg[2] ? div_step : mul_step;
    end

    // A kept remainder is always below the divisor, so bit 32 of the trial is zero there.
    assign unused_bits = rem_trial[32];

    // Sign restoration; divide-by-zero overrides, signed overflow falls out naturally.
    always_comb begin
        sign_diff   = a_neg_reg ^ b_neg_reg;
        prod_signed = sign_diff ? (~prod_reg + 64'd1) : prod_reg;
        quo_fix     = b_zero_reg ? 32'hFFFF_FFFF
                                 : (sign_diff ? (~prod_reg[31:0] + 32'd1) : prod_reg[31:0]);
        rem_fix     = b_zero_reg ? a_orig_reg
                                 : (a_neg_reg ? (~prod_reg[63:32] + 32'd1) : prod_reg[63:32]);
        case (funct3_reg)
            3'b000:                 result_next = prod_signed[31:0];
            3'b001, 3'b010, 3'b011: result_next = prod_signed[63:32];
            3'b100, 3'b101:         result_next = quo_fix;
            default:                result_next = rem_fix;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state_reg  <= ST_IDLE;
            step_reg   <= 5'd0;
            funct3_reg <= 3'd0;
            a_orig_reg <= 32'd0;
            opnd_reg   <= 32'd0;
            prod_reg   <= 64'd0;
            a_neg_reg  <= 1'b0;
            b_neg_reg  <= 1'b0;
            b_zero_reg <= 1'b0;
            done_reg   <= 1'b0;
            result_reg <= 32'd0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.i_Start) begin
                        state_reg  <= ST_CALC;
                        step_reg   <= 5'd31;
                        funct3_reg <= bus.i_Funct3;
                        a_orig_reg <= bus.i_Operand_A;
                        opnd_reg   <= b_mag_in;
                        prod_reg   <= {32'd0, a_mag_in};
                        a_neg_reg  <= a_neg_in;
                        b_neg_reg  <= b_neg_in;
                        b_zero_reg <= (bus.i_Operand_B == 32'd0);
                    end
                end
                ST_CALC: begin
                    prod_reg <= step_next;
                    step_reg <= step_reg - 5'd1;
                    if (step_reg == 5'd0) begin
                        state_reg <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    result_reg <= result_next;
                    done_reg   <= 1'b1;
                    state_reg  <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_Busy   = (state_reg != ST_IDLE);
    assign bus.o_Done   = done_reg;
    assign bus.o_Result = result_reg;
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed check of mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    mul_div_unit_if bus_if ();

    mul_div_unit dut (
        .i_Clk   (clk),
        .i_Reset (rst_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end else begin
            $display("ok   %s got=%08h", tag, got);
        end
    endtask

    // Reference: plain 64-bit arithmetic and RISC-V corner-case rules.
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        int          ia;
        int          ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        p  = 64'd0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bus_if.i_Funct3    = f;
        bus_if.i_Operand_A = a;
        bus_if.i_Operand_B = b;
        bus_if.i_Start     = 1'b1;
        @(posedge clk);
        #1;
        bus_if.i_Start = 1'b0;
    endtask

    task automatic wait_done(input int already, output int lat);
        lat = already;
        while (bus_if.o_Done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int lat;
        start_op(f, a, b);
        check_val({tag, "_busy"}, {31'd0, bus_if.o_Busy}, 32'd1);
        wait_done(0, lat);
        check_val({tag, "_lat"}, lat, 32'd33);
        check_val({tag, "_idle"}, {31'd0, bus_if.o_Busy}, 32'd0);
        check_val(tag, bus_if.o_Result, ref_op(f, a, b));
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.o_Done === 1'b1) pulses++;
        end
    endtask

    logic [2:0]  dir_f [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                3'd4, 3'd6, 3'd4, 3'd6};
    logic [31:0] dir_a [12] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                                32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] dir_b [12] = '{32'd3, 32'd3, 32'd3, 32'd3, 32'd2, 32'd2, 32'd2, 32'd2,
                                32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] dir_x [12] = '{32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF,
                                32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h0000_0001,
                                32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'h0000_0000};
    logic [31:0] corner [4] = '{32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1};

    initial begin
        int          lat;
        int          pulses;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;

        bus_if.i_Start     = 1'b0;
        bus_if.i_Funct3    = 3'd0;
        bus_if.i_Operand_A = 32'd0;
        bus_if.i_Operand_B = 32'd0;

        // Reset state, then idle with start low.
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", {31'd0, bus_if.o_Busy}, 32'd0);
        check_val("rst_done", {31'd0, bus_if.o_Done}, 32'd0);
        check_val("rst_result", bus_if.o_Result, 32'd0);
        rst_n = 1'b1;
        count_done(10, pulses);
        check_val("idle_pulses", pulses, 32'd0);
        check_val("idle_result", bus_if.o_Result, 32'd0);
        check_val("idle_busy", {31'd0, bus_if.o_Busy}, 32'd0);

        // Directed vectors, each also checked against a hand-derived constant.
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("dir%0d", i), dir_f[i], dir_a[i], dir_b[i]);
            check_val($sformatf("dir%0d_const", i), bus_if.o_Result, dir_x[i]);
        end

        // Inputs change and a stray start during CALC must not disturb the op.
        start_op(3'd5, 32'h1234_5678, 32'h0000_0123);
        for (int i = 0; i < 5; i++) begin
            bus_if.i_Operand_A = $urandom;
            bus_if.i_Operand_B = $urandom;
            bus_if.i_Funct3    = 3'd3;
            bus_if.i_Start     = (i == 2);
            @(posedge clk);
            #1;
        end
        bus_if.i_Start = 1'b0;
        wait_done(5, lat);
        check_val("hs_lat", lat, 32'd33);
        check_val("hs_result", bus_if.o_Result, ref_op(3'd5, 32'h1234_5678, 32'h0000_0123));
        count_done(40, pulses);
        check_val("hs_no_extra", pulses, 32'd0);

        // Back-to-back: next start issued in the o_Done cycle.
        run_op("b2b_a", 3'd1, 32'h8000_0000, 32'h8000_0000);
        check_val("b2b_done_cycle", {31'd0, bus_if.o_Done}, 32'd1);
        run_op("b2b_b", 3'd6, 32'h8765_4321, 32'h0000_1000);

        // Randomized ops with occasional corner operands.
        for (int i = 0; i < 50; i++) begin
            f = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 32'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 32'($urandom);
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(8, 28);
            run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b);
        end

        // Reset in the middle of CALC: no completion, result cleared.
        start_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #2;
        check_val("mid_rst_busy", {31'd0, bus_if.o_Busy}, 32'd0);
        check_val("mid_rst_done", {31'd0, bus_if.o_Done}, 32'd0);
        check_val("mid_rst_result", bus_if.o_Result, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_done(40, pulses);
        check_val("mid_rst_pulses", pulses, 32'd0);
        check_val("mid_rst_hold", bus_if.o_Result, 32'd0);
        run_op("post_rst_mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_val("post_rst_const", bus_if.o_Result, 32'hFFFF_FFFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide unit for the multi-cycle core. It sits directly downstream of the register file and takes the two read-port values (rs1, rs2) as operands when the control FSM issues an M-extension instruction. It produces one 32-bit result for the writeback path after a fixed latency. It uses a single shared 32-step shift/add/subtract datapath, not a combinational multiplier or divider.

## Interface
- No parameters (XLEN fixed at 32).
- i_Clk  input  1  clock; all state updates on rising edge.
- i_Reset  input  1  asynchronous, active-low reset.
- i_Start  input  1  request; sampled only in IDLE.
- i_Funct3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_Operand_A  input  32  rs1 value (register-file read port 1).
- i_Operand_B  input  32  rs2 value (register-file read port 2).
- o_Busy  output  1  high from the cycle after acceptance until the cycle o_Done is high (exclusive).
- o_Done  output  1  single-cycle pulse; o_Result is valid.
- o_Result  output  32  result; held until the next o_Done.

## Operation
- **States:** IDLE, CALC, FIX.
  - IDLE + i_Start → CALC.
  - CALC for exactly 32 iterations (5-bit step counter, 31 down to 0) → FIX.
  - FIX → IDLE.
- **On acceptance**, latch i_Funct3, both operands, sign flags and magnitudes. Later changes on the inputs have no effect.
- **Signedness:**
  - A is signed for MULH, MULHSU, DIV, REM.
  - B is signed for MULH, DIV, REM.
  - MUL's low word is sign-agnostic; compute it as unsigned.
  - A magnitude is a 32-bit unsigned value, so |−2^31| = 0x8000_0000.
- **Multiply:** 64-bit product register. Each CALC step: if multiplier LSB is 1, add the multiplicand into the upper 33 bits (carry kept), then shift right 1. In FIX, two's-complement negate the 64-bit product if the operand signs differ. MUL selects bits [31:0]; MULH/MULHSU/MULHU select bits [63:32].
- **Divide:** restoring algorithm on magnitudes.
  - Each CALC step: shift the {remainder, quotient} pair left 1 and trial-subtract the divisor from the 33-bit remainder.
  - If the result is non-negative, keep it and set quotient LSB to 1.
- **FIX for divide:**
  - Negate the quotient if the signs differ.
  - The remainder takes the dividend's sign.
  - Divisor == 0 overrides: quotient = 0xFFFF_FFFF and remainder = original A, for both signed and unsigned ops.
  - Signed overflow (A = 0x8000_0000, B = 0xFFFF_FFFF) must give quotient 0x8000_0000 and remainder 0. The magnitude path already yields this; do not special-case it to another value.
- **i_Start while busy:** ignored. No queueing, no error flag.

## Timing
- **Reset values:** state IDLE, o_Busy 0, o_Done 0, o_Result 0x0000_0000, step counter 0, datapath registers 0.
- **Latency:** i_Start sampled high in IDLE at edge E0.
  - CALC iterations occur at edges E1..E32.
  - FIX updates o_Result and sets o_Done at E33.
  - o_Done is high during the cycle following E33 only: 33 cycles from request to o_Done.
  - The latency is the same for every op, including divide-by-zero.
- **o_Busy:** 1 in the cycles after E0 through E32; 0 from E33 onward.
- **Back-to-back requests:** i_Start may be high in the same cycle as o_Done. The FSM is already in IDLE, so it accepts, and the next o_Done comes 33 cycles later.
- **Held i_Start:** if it stays high continuously, the unit restarts immediately after each completion.
- **Reset mid-operation:** asserting i_Reset at any point forces the reset values asynchronously. The in-flight operation is lost and no o_Done is produced. The first acceptance after reset deassertion behaves normally.
- **o_Result:** changes only at a FIX edge or on reset.

## Test plan
- **Reset and idle:** assert i_Reset mid-stream, then release with i_Start low → o_Busy = 0, o_Done = 0, o_Result = 0 held indefinitely.
- **MUL/MULH signed:** A = 0xFFFF_FFFE (−2), B = 0x0000_0003 → MUL result 0xFFFF_FFFA, MULH 0xFFFF_FFFF, MULHU 0x0000_0002, MULHSU 0xFFFF_FFFF. o_Done arrives exactly 33 cycles after the accepting edge.
- **DIV/REM signs:** A = −7 (0xFFFF_FFF9), B = 2 → DIV 0xFFFF_FFFD (−3), REM 0xFFFF_FFFF (−1), DIVU 0x7FFF_FFFC, REMU 0x0000_0001.
- **Boundary cases:**
  - DIV with B = 0, A = 0x1234_5678 → 0xFFFF_FFFF; REM → 0x1234_5678.
  - DIV with A = 0x8000_0000, B = 0xFFFF_FFFF → 0x8000_0000; REM → 0.
- **Handshake:**
  - Change A/B and pulse i_Start during CALC → the result reflects the original operands and the extra start is ignored.
  - i_Start high in the o_Done cycle → the second op is accepted, giving o_Done pulses 33 cycles apart.
- **Reset mid-CALC:** pulse i_Reset low at cycle 15 → no o_Done, o_Result = 0. A new MULHU 0xFFFF_FFFF × 0xFFFF_FFFF then returns 0xFFFF_FFFE.
